// File: rtl/dfi_rd_return.sv
// dfi_rd_return: read-return stage directly downstream of the PHY's DFI read
// interface. Each issued read pushes its ID into a tag FIFO; incoming DFI beats
// are tagged with the head ID, grouped into bursts of BURST_BEATS, buffered in a
// data FIFO and returned on a valid/ready response channel. The PHY cannot be
// stalled, so issue is gated on buffer credit reserved per read.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   rd_issue_*        read issue from the scheduler (valid/ready, ID)
//   dfi_rddata*       DFI read beats from the PHY (no back-pressure)
//   rresp_*           response beats to the requester (valid/ready, ID, data, last)
//   outstanding       reads issued whose last beat has not yet arrived
//   err_unexpected    sticky: a beat arrived with no outstanding tag
module dfi_rd_return #(
  parameter int DATA_WIDTH  = 128,
  parameter int ID_WIDTH    = 4,
  parameter int BURST_BEATS = 2,
  parameter int TAG_DEPTH   = 8,
  parameter int DATA_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rd_issue_valid,
  input  logic [ID_WIDTH-1:0]          rd_issue_id,
  output logic                         rd_issue_ready,
  input  logic                         dfi_rddata_valid,
  input  logic [DATA_WIDTH-1:0]        dfi_rddata,
  output logic                         rresp_valid,
  input  logic                         rresp_ready,
  output logic [ID_WIDTH-1:0]          rresp_id,
  output logic [DATA_WIDTH-1:0]        rresp_data,
  output logic                         rresp_last,
  output logic [$clog2(TAG_DEPTH):0]   outstanding,
  output logic                         err_unexpected
);
  localparam int TAW = $clog2(TAG_DEPTH);
  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int CW  = DAW + 1;
  localparam int BCW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

  // Tag FIFO: pointers carry an extra wrap bit.
  logic [ID_WIDTH-1:0]   tag_mem [TAG_DEPTH];
  logic [TAW:0]          tag_wp, tag_rp;
  // Data FIFO.
  logic [ID_WIDTH-1:0]   id_mem   [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DATA_DEPTH];
  logic                  last_mem [DATA_DEPTH];
  logic [DAW:0]          dat_wp, dat_rp;

  logic [CW-1:0]         credit, credit_nxt;
  logic [BCW-1:0]        beat_cnt;
  logic                  err_q;

  logic tag_empty, tag_full, dat_empty;
  logic issue_acc, beat_cap, beat_last, tag_pop, rsp_pop;

  assign tag_empty = (tag_wp == tag_rp);
  assign tag_full  = (tag_wp[TAW] != tag_rp[TAW]) &&
                     (tag_wp[TAW-1:0] == tag_rp[TAW-1:0]);
  assign dat_empty = (dat_wp == dat_rp);

  // Ready depends on registered state only, never on same-cycle pops.
  assign rd_issue_ready = !tag_full && (credit >= CW'(BURST_BEATS));
  assign issue_acc      = rd_issue_valid && rd_issue_ready;

  // A tag pushed this cycle is not yet visible to a beat in the same cycle.
  assign beat_cap  = dfi_rddata_valid && !tag_empty;
  assign beat_last = (beat_cnt == BCW'(BURST_BEATS - 1));
  assign tag_pop   = beat_cap && beat_last;

  assign rresp_valid = !dat_empty;
  assign rsp_pop     = rresp_valid && rresp_ready;

  assign outstanding    = tag_wp - tag_rp;
  assign err_unexpected = err_q;

  // Credit reserves a full burst at issue and returns one slot per pop.
  always_comb begin
    credit_nxt = credit;
    if (issue_acc) credit_nxt = credit_nxt - CW'(BURST_BEATS);
    if (rsp_pop)   credit_nxt = credit_nxt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_wp   <= '0;
      tag_rp   <= '0;
      dat_wp   <= '0;
      dat_rp   <= '0;
      credit   <= CW'(DATA_DEPTH);
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      credit <= credit_nxt;
      if (issue_acc) tag_wp <= tag_wp + 1'b1;
      if (tag_pop)   tag_rp <= tag_rp + 1'b1;
      if (beat_cap) begin
        dat_wp   <= dat_wp + 1'b1;
        beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
      end
      if (rsp_pop) dat_rp <= dat_rp + 1'b1;
      if (dfi_rddata_valid && tag_empty) err_q <= 1'b1;
    end
  end

  // Storage needs no reset: pointers define what is valid.
  always_ff @(posedge clk) begin
    if (issue_acc) tag_mem[tag_wp[TAW-1:0]] <= rd_issue_id;
    if (beat_cap) begin
      id_mem[dat_wp[DAW-1:0]]   <= tag_mem[tag_rp[TAW-1:0]];
      data_mem[dat_wp[DAW-1:0]] <= dfi_rddata;
      last_mem[dat_wp[DAW-1:0]] <= beat_last;
    end
  end

  // Head of the registered buffer; forced to zero while empty so outputs are
  // clean after reset. Stable under back-pressure since dat_rp only moves on pop.
  assign rresp_id   = rresp_valid ? id_mem[dat_rp[DAW-1:0]]   : '0;
  assign rresp_data = rresp_valid ? data_mem[dat_rp[DAW-1:0]] : '0;
  assign rresp_last = rresp_valid ? last_mem[dat_rp[DAW-1:0]] : 1'b0;
endmodule
